grey6_monitor: RTL and testbench



---
 rtl/grey6_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_grey6_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/grey6_monitor.sv
// grey6_monitor: on-chip checker for the 6-bit grey-code counter chain.
// Samples the grey bus, converts it to binary, and checks that every
// change is a single +1 step arriving exactly PERIOD clocks after the
// previous one. Reports lock, error pulses, a saturating error count
// and the measured interval between the last two changes.
//
// Optional build macro: GREY6_MONITOR_SYNC_EN
//   defined   - grey passes through a two-flop synchronizer before the
//               sample register (asynchronous source allowed, latency 4)
//   undefined - grey feeds the sample register directly (latency 2)
//
// FSM states: IDLE    - waiting for the first change, never flags errors
//             ACQUIRE - counting consecutive good steps towards lock
//             LOCKED  - locked; any bad step, wrong interval or stall
//                       drops back to ACQUIRE
//
// Handshake: none. grey is a free-running level input; step and err are
// single-cycle pulses with no back-pressure.

module grey6_monitor #(
  parameter int PERIOD   = 5,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] grey,
  output logic [5:0] bin,
  output logic       step,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       locked,
  output logic [7:0] interval
);

  // Compare constants sized to the registers they are compared against.
  localparam logic [7:0] C_PERIOD = 8'(PERIOD);
  localparam logic [7:0] C_STALL  = 8'(2 * PERIOD);
  localparam logic [3:0] C_LOCK   = 4'(LOCK_CNT);
  localparam logic [7:0] C_SAT    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Grey to binary: MSB passes through, each lower bit is XOR of the
  // binary bit above it and its own grey bit.
  function automatic logic [5:0] grey2bin(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [5:0] w_grey_in;
  logic [5:0] r_g_s;
  logic [5:0] r_g_p;
  logic [7:0] r_ivl;
  logic [3:0] r_good;
  state_t     r_state;

  logic [5:0] w_bin_s;
  logic [5:0] w_bin_p;
  logic [5:0] w_bin_p_inc;
  logic       w_chg;
  logic       w_inc;
  logic       w_bad;
  logic       w_ivl_ok;
  logic       w_stall;
  logic       w_step_ev;
  logic       w_err_ev;

`ifdef GREY6_MONITOR_SYNC_EN
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;

  // Two-flop synchronizer for an asynchronous grey source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= grey;
      r_sync2 <= r_sync1;
    end
  end

  assign w_grey_in = r_sync2;
`else
  assign w_grey_in = grey;
`endif

  // Sample and previous-sample registers feeding the comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g_s <= '0;
      r_g_p <= '0;
    end else begin
      r_g_s <= w_grey_in;
      r_g_p <= r_g_s;
    end
  end

  // Classification of the current sample against the previous one.
  assign w_bin_s     = grey2bin(r_g_s);
  assign w_bin_p     = grey2bin(r_g_p);
  assign w_bin_p_inc = w_bin_p + 6'd1;   // 6-bit add wraps 63 -> 0
  assign w_chg       = (r_g_s != r_g_p);
  assign w_inc       = w_chg && (w_bin_s == w_bin_p_inc);
  assign w_bad       = w_chg && !w_inc;
  assign w_ivl_ok    = (r_ivl == C_PERIOD);
  assign w_stall     = !w_chg && (r_ivl == C_STALL);

  // Step and error events; only one err can occur per clock since a
  // stall needs no change while every other error needs a change.
  assign w_step_ev = (r_state != ST_IDLE) && w_inc;
  assign w_err_ev  = ((r_state != ST_IDLE) && (w_bad || (w_inc && !w_ivl_ok)))
                   || ((r_state == ST_LOCKED) && w_stall);

  // Registered binary view of the sample, independent of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin <= '0;
    end else begin
      bin <= w_bin_s;
    end
  end

  // Interval measurement: running count since the last change, latched
  // into interval on each change; both saturate at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ivl    <= '0;
      interval <= '0;
    end else if (w_chg) begin
      interval <= r_ivl;
      r_ivl    <= 8'd1;
    end else if (r_ivl != C_SAT) begin
      r_ivl <= r_ivl + 8'd1;
    end
  end

  // Saturating error counter, bumped on every err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (w_err_ev && (err_cnt != C_SAT)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Lock FSM with registered step/err/locked outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_good  <= '0;
      step    <= 1'b0;
      err     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      step <= w_step_ev;
      err  <= w_err_ev;
      case (r_state)
        ST_IDLE: begin
          // First change is only a reference point, never evaluated.
          if (w_chg) begin
            r_state <= ST_ACQUIRE;
            r_good  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (w_inc && w_ivl_ok) begin
            if ((r_good + 4'd1) == C_LOCK) begin
              r_state <= ST_LOCKED;
              locked  <= 1'b1;
              r_good  <= C_LOCK;
            end else begin
              r_good <= r_good + 4'd1;
            end
          end else if (w_chg) begin
            // Wrong interval or bad step restarts the good-step count.
            r_good <= '0;
          end
        end
        ST_LOCKED: begin
          if ((w_chg && !(w_inc && w_ivl_ok)) || w_stall) begin
            r_state <= ST_ACQUIRE;
            locked  <= 1'b0;
            r_good  <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          locked  <= 1'b0;
          r_good  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grey6_monitor.sv
// Directed testbench for grey6_monitor (PERIOD=5, LOCK_CNT=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_grey6_monitor;

`ifdef GREY6_MONITOR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic [5:0] grey;
  logic [5:0] bin;
  logic       step;
  logic       err;
  logic [7:0] err_cnt;
  logic       locked;
  logic [7:0] interval;

  int n_chk;
  int n_err;
  int pulses;

  grey6_monitor #(.PERIOD(5), .LOCK_CNT(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .grey     (grey),
    .bin      (bin),
    .step     (step),
    .err      (err),
    .err_cnt  (err_cnt),
    .locked   (locked),
    .interval (interval)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive binary value b (as grey) gap clocks after the previous change,
  // then check the outputs LAT clocks later.
  task automatic change(input logic [5:0] b, input int gap, input logic e_step,
                        input logic e_err, input logic e_lock, input string tag);
    repeat (gap - LAT) tick();
    grey = b ^ (b >> 1);
    repeat (LAT) tick();
    check({tag, ".step"}, 32'(step), 32'(e_step));
    check({tag, ".err"}, 32'(err), 32'(e_err));
    check({tag, ".bin"}, 32'(bin), 32'(b));
    check({tag, ".locked"}, 32'(locked), 32'(e_lock));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".bin"}, 32'(bin), 0);
    check({tag, ".step"}, 32'(step), 0);
    check({tag, ".err"}, 32'(err), 0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 0);
    check({tag, ".locked"}, 32'(locked), 0);
    check({tag, ".interval"}, 32'(interval), 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    grey  = 6'd0;
    rst   = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) tick();

    // 1: IDLE change then four good steps -> lock on the fifth change
    change(6'd1, 5, 0, 0, 0, "t1_idle");
    for (int b = 2; b <= 4; b++) change(6'(b), 5, 1, 0, 0, "t1_acq");
    change(6'd5, 5, 1, 0, 1, "t1_lock");
    change(6'd6, 5, 1, 0, 1, "t1_s6");
    change(6'd7, 5, 1, 0, 1, "t1_s7");
    check("t1_interval", 32'(interval), 5);
    check("t1_err_cnt", 32'(err_cnt), 0);

    // 2: skip 7 -> 10 is a bad step, then relock
    change(6'd10, 5, 0, 1, 0, "t2_bad");
    check("t2_err_cnt", 32'(err_cnt), 1);
    for (int b = 11; b <= 13; b++) change(6'(b), 5, 1, 0, 0, "t2_acq");
    change(6'd14, 5, 1, 0, 1, "t2_relock");

    // 3: change 6 clocks apart -> step and err together
    change(6'd15, 6, 1, 1, 0, "t3_late");
    check("t3_interval", 32'(interval), 6);
    check("t3_err_cnt", 32'(err_cnt), 2);
    for (int b = 16; b <= 18; b++) change(6'(b), 5, 1, 0, 0, "t3_acq");
    change(6'd19, 5, 1, 0, 1, "t3_relock");

    // 4: stall -> one err when ivl reaches 10
    pulses = 0;
    repeat (9) begin
      tick();
      if (err) pulses++;
    end
    check("t4_pre_stall_err", 32'(pulses), 0);
    tick();
    check("t4_stall_err", 32'(err), 1);
    check("t4_stall_locked", 32'(locked), 0);
    check("t4_err_cnt", 32'(err_cnt), 3);
    pulses = 0;
    repeat (2) begin
      tick();
      if (err) pulses++;
    end
    check("t4_post_stall_err", 32'(pulses), 0);
    change(6'd20, LAT, 1, 1, 0, "t4_resume");
    check("t4_resume_err_cnt", 32'(err_cnt), 4);
    for (int b = 21; b <= 23; b++) change(6'(b), 5, 1, 0, 0, "t4_acq");
    change(6'd24, 5, 1, 0, 1, "t4_relock");

    // 5: run to 63, wrap to 0, then saturate err_cnt
    for (int b = 25; b <= 63; b++) change(6'(b), 5, 1, 0, 1, "t5_run");
    change(6'd0, 5, 1, 0, 1, "t5_wrap");
    check("t5_wrap_interval", 32'(interval), 5);
    check("t5_wrap_err_cnt", 32'(err_cnt), 4);
    for (int i = 0; i < 300; i++) begin
      grey = (i % 2 == 0) ? 6'b000011 : 6'b000000;
      tick();
    end
    repeat (LAT) tick();
    check("t5_sat_err_cnt", 32'(err_cnt), 255);
    check("t5_sat_err_idle", 32'(err), 0);
    check("t5_sat_locked", 32'(locked), 0);
    change(6'd1, 4, 1, 0, 0, "t5_acq");
    change(6'd2, 5, 1, 0, 0, "t5_acq");
    change(6'd3, 5, 1, 0, 0, "t5_acq");
    change(6'd4, 5, 1, 0, 1, "t5_relock");
    check("t5_relock_err_cnt", 32'(err_cnt), 255);

    // 6: asynchronous reset between edges, then unevaluated first change
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_async_rst");
    repeat (2) tick();
    rst = 1'b0;
    repeat (LAT) tick();
    check("t6_first_step", 32'(step), 0);
    check("t6_first_err", 32'(err), 0);
    check("t6_first_bin", 32'(bin), 4);
    check("t6_first_locked", 32'(locked), 0);
    change(6'd5, 5, 1, 0, 0, "t6_step");
    check("t6_err_cnt", 32'(err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
